// File: rtl/run_ctrl.sv
// Run-control sequencer: gates PC commit and sequences reset/run/halt/step/error for the core.
// Optional hardware breakpoint compare is built when RUNCTL_BREAKPOINT_EN is defined.
module run_ctrl #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [5:0]            exceptions_i,
    input  logic                  halt_req_i,
    input  logic                  resume_req_i,
    input  logic                  step_req_i,
    input  logic                  bp_valid_i,
    input  logic [DATA_WIDTH-1:0] bp_addr_i,
    output logic                  pc_we_o,
    output logic [2:0]            state_o,
    output logic [3:0]            cause_o,
    output logic [DATA_WIDTH-1:0] cause_pc_o,
    output logic [CNT_WIDTH-1:0]  cycle_o,
    output logic [CNT_WIDTH-1:0]  instret_o,
    output logic                  dbg_ack_o
);

    typedef enum logic [2:0] {
        StRst   = 3'd0,
        StRun   = 3'd1,
        StHalt  = 3'd2,
        StError = 3'd3,
        StStep  = 3'd4
    } state_e;

    localparam logic [3:0] CauseEcall  = 4'd4;
    localparam logic [3:0] CauseEbreak = 4'd5;
    localparam logic [3:0] CauseBp     = 4'd6;
    localparam logic [3:0] CauseHalt   = 4'd7;
    localparam logic [3:0] CauseStep   = 4'd8;

    state_e                state_q, state_d;
    logic [3:0]            cause_q, stop_cause;
    logic [DATA_WIDTH-1:0] cause_pc_q;
    logic [CNT_WIDTH-1:0]  cycle_q, instret_q;
    logic                  dbg_ack_q;
    logic                  active, bp_hit, pc_we;
    logic [3:0]            anomaly_cause;

    assign active = (state_q == StRun) || (state_q == StStep);

`ifdef RUNCTL_BREAKPOINT_EN
    // High for the first RUN/STEP cycle after HALT so a resume at the bp PC makes progress.
    logic bp_supp_q;
    assign bp_hit = bp_valid_i && (pc_i == bp_addr_i) && !bp_supp_q;
`else
    logic unused_bp;
    assign unused_bp = ^{bp_valid_i, bp_addr_i};
    assign bp_hit    = 1'b0;
`endif

    assign pc_we = active && (exceptions_i == 6'd0) && !bp_hit;

    // Lowest set anomaly bit wins.
    always_comb begin
        anomaly_cause = 4'd0;
        for (int i = 3; i >= 0; i--) begin
            if (exceptions_i[i]) begin
                anomaly_cause = 4'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        stop_cause = cause_q;
        unique case (state_q)
            StRst: begin
                if (halt_req_i) begin
                    state_d    = StHalt;
                    stop_cause = CauseHalt;
                end else begin
                    state_d = StRun;
                end
            end
            StRun, StStep: begin
                if (|exceptions_i[3:0]) begin
                    state_d    = StError;
                    stop_cause = anomaly_cause;
                end else if (exceptions_i[4]) begin
                    state_d    = StHalt;
                    stop_cause = CauseEcall;
                end else if (exceptions_i[5]) begin
                    state_d    = StHalt;
                    stop_cause = CauseEbreak;
                end else if (bp_hit) begin
                    state_d    = StHalt;
                    stop_cause = CauseBp;
                end else if (halt_req_i && (state_q == StRun)) begin
                    state_d    = StHalt;
                    stop_cause = CauseHalt;
                end else if (state_q == StStep) begin
                    state_d    = StHalt;
                    stop_cause = CauseStep;
                end
            end
            StHalt: begin
                if (resume_req_i) begin
                    state_d = StRun;
                end else if (step_req_i) begin
                    state_d = StStep;
                end
            end
            StError: state_d = StError;
            default: state_d = StRst;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StRst;
            cause_q    <= 4'd0;
            cause_pc_q <= '0;
            cycle_q    <= '0;
            instret_q  <= '0;
            dbg_ack_q  <= 1'b0;
`ifdef RUNCTL_BREAKPOINT_EN
            bp_supp_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if ((state_d != state_q) && ((state_d == StHalt) || (state_d == StError))) begin
                cause_q    <= stop_cause;
                cause_pc_q <= pc_i;
            end
            dbg_ack_q <= (state_d == StHalt) != (state_q == StHalt);
            if (state_q != StRst) begin
                cycle_q <= cycle_q + CNT_WIDTH'(1);
            end
            if (pc_we) begin
                instret_q <= instret_q + CNT_WIDTH'(1);
            end
`ifdef RUNCTL_BREAKPOINT_EN
            bp_supp_q <= (state_q == StHalt) && (state_d != StHalt);
`endif
        end
    end

    assign pc_we_o    = pc_we;
    assign state_o    = state_q;
    assign cause_o    = cause_q;
    assign cause_pc_o = cause_pc_q;
    assign cycle_o    = cycle_q;
    assign instret_o  = instret_q;
    assign dbg_ack_o  = dbg_ack_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: driver pushes per-cycle expected outputs from a rule-level model,
// a negedge monitor pops and compares them.
module tb_run_ctrl;

    localparam int CW = 8;
    localparam logic [63:0] PB = 64'h8000_0000;
    localparam int RST = 0, RUN = 1, HALT = 2, ERROR = 3, STEP = 4;
`ifdef RUNCTL_BREAKPOINT_EN
    localparam bit BP_ON = 1'b1;
`else
    localparam bit BP_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [63:0]   pc = '0;
    logic [5:0]    exc = '0;
    logic          halt_req = 1'b0, resume_req = 1'b0, step_req = 1'b0, bp_valid = 1'b0;
    logic [63:0]   bp_addr = '0;
    logic          pc_we;
    logic [2:0]    state;
    logic [3:0]    cause;
    logic [63:0]   cause_pc;
    logic [CW-1:0] cycle, instret;
    logic          dbg_ack;

    run_ctrl #(.DATA_WIDTH(64), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_i(rst), .pc_i(pc), .exceptions_i(exc),
        .halt_req_i(halt_req), .resume_req_i(resume_req), .step_req_i(step_req),
        .bp_valid_i(bp_valid), .bp_addr_i(bp_addr),
        .pc_we_o(pc_we), .state_o(state), .cause_o(cause), .cause_pc_o(cause_pc),
        .cycle_o(cycle), .instret_o(instret), .dbg_ack_o(dbg_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    st;
        logic [3:0]    cause;
        logic [63:0]   cpc;
        logic [CW-1:0] cyc;
        logic [CW-1:0] ir;
        logic          ack;
        logic          we;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    int            m_st = RST;
    int            m_cause = 0;
    logic [63:0]   m_cpc = '0;
    logic [CW-1:0] m_cyc = '0, m_ir = '0;
    bit            m_ack = 1'b0, m_supp = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    // Drive one cycle's inputs, record what the DUT must show this cycle, then advance the model.
    task automatic cyc(input logic r, input logic [5:0] ex, input logic h, input logic rs,
                       input logic s, input logic bv, input logic [63:0] ba, input logic [63:0] pcv);
        exp_t e;
        bit   act, hit, we;
        int   ns, nc;
        rst = r; exc = ex; halt_req = h; resume_req = rs; step_req = s;
        bp_valid = bv; bp_addr = ba; pc = pcv;
        act = (m_st == RUN) || (m_st == STEP);
        hit = BP_ON && bv && (pcv == ba) && !m_supp && act;
        we  = act && (ex == 6'd0) && !hit;
        e.st = 3'(m_st); e.cause = 4'(m_cause); e.cpc = m_cpc; e.cyc = m_cyc; e.ir = m_ir;
        e.ack = m_ack; e.we = we;
        sb.push_back(e);
        if (r) begin
            m_st = RST; m_cause = 0; m_cpc = '0; m_cyc = '0; m_ir = '0; m_ack = 0; m_supp = 0;
        end else begin
            ns = m_st; nc = m_cause;
            if (m_st == RST) begin
                ns = h ? HALT : RUN;
                if (h) nc = 7;
            end else if (act) begin
                if (ex[3:0] != 4'd0) begin
                    ns = ERROR;
                    for (int i = 3; i >= 0; i--) if (ex[i]) nc = i;
                end else if (ex[4]) begin ns = HALT; nc = 4; end
                else if (ex[5]) begin ns = HALT; nc = 5; end
                else if (hit) begin ns = HALT; nc = 6; end
                else if (h && m_st == RUN) begin ns = HALT; nc = 7; end
                else if (m_st == STEP) begin ns = HALT; nc = 8; end
            end else if (m_st == HALT) begin
                if (rs) ns = RUN;
                else if (s) ns = STEP;
            end
            if (ns != m_st && (ns == HALT || ns == ERROR)) begin
                m_cause = nc; m_cpc = pcv;
            end
            m_ack  = (ns == HALT) != (m_st == HALT);
            m_supp = (m_st == HALT) && (ns != HALT);
            if (m_st != RST) m_cyc++;
            if (we) m_ir++;
            m_st = ns;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [63:0] pcv);
        cyc(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, pcv);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("state", 64'(state), 64'(e.st));
                chk("cause", 64'(cause), 64'(e.cause));
                chk("cause_pc", cause_pc, e.cpc);
                chk("cycle", 64'(cycle), 64'(e.cyc));
                chk("instret", 64'(instret), 64'(e.ir));
                chk("dbg_ack", 64'(dbg_ack), 64'(e.ack));
                chk("pc_we", 64'(pc_we), 64'(e.we));
            end
        end
    end

    initial begin : driver
        logic [5:0]  ex;
        logic [63:0] ba;
        int          k;
        repeat (2) @(posedge clk);
        #1;

        // Run ten clean instructions, then ECALL
        cyc(1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, PB);
        idle(PB);
        for (int i = 0; i < 10; i++) idle(PB + 64'(4 * i));
        cyc(1'b0, 6'b010000, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'h8000_0028);
        chk("ecall_state", 64'(state), 64'd2);
        chk("ecall_cause", 64'(cause), 64'd4);
        chk("ecall_pc", cause_pc, 64'h8000_0028);
        chk("ecall_instret", 64'(instret), 64'd10);
        idle(64'h8000_002c);

        // Anomaly beats EBREAK; ERROR ignores debug requests
        cyc(1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, PB);
        idle(PB);
        idle(PB);
        cyc(1'b0, 6'b100100, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, PB + 64'd4);
        chk("err_state", 64'(state), 64'd3);
        chk("err_cause", 64'(cause), 64'd2);
        for (int i = 0; i < 3; i++) cyc(1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0, 64'd0, PB);
        chk("err_sticky", 64'(state), 64'd3);
        cyc(1'b1, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, PB);
        chk("err_reset", 64'(state), 64'd0);

        // Halt, single step, resume
        idle(PB);
        idle(PB);
        cyc(1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, PB + 64'd4);
        chk("halt_cause", 64'(cause), 64'd7);
        chk("halt_ack", 64'(dbg_ack), 64'd1);
        idle(PB + 64'd4);
        cyc(1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, PB + 64'd4);
        chk("step_state", 64'(state), 64'd4);
        idle(PB + 64'd4);
        chk("step_done", 64'(cause), 64'd8);
        cyc(1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, PB + 64'd8);
        chk("resume_state", 64'(state), 64'd1);
        idle(PB + 64'd8);

        // Breakpoint at PB+0x10, then resume from it
        for (int i = 3; i <= 4; i++)
            cyc(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, PB + 64'h10, PB + 64'(4 * i));
        if (BP_ON) chk("bp_cause", 64'(cause), 64'd6);
        cyc(1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, PB + 64'h10, PB + 64'h10);
        cyc(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, PB + 64'h10, PB + 64'h10);
        chk("bp_resume", 64'(state), 64'd1);
        cyc(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, PB + 64'h10, PB + 64'h14);

        // EBREAK with halt request; then resume and step together
        cyc(1'b0, 6'b100000, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, PB + 64'h18);
        chk("ebreak_cause", 64'(cause), 64'd5);
        cyc(1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, PB + 64'h1c);
        chk("resume_wins", 64'(state), 64'd1);

        // Boot halted, then reset during STEP
        cyc(1'b1, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, PB);
        cyc(1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, PB);
        chk("boot_halt", 64'(state), 64'd2);
        chk("boot_cause", 64'(cause), 64'd7);
        cyc(1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, PB);
        cyc(1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, PB);
        chk("step_rst_state", 64'(state), 64'd0);
        chk("step_rst_cause", 64'(cause), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            k = int'($urandom_range(0, 39));
            if (k == 0) ex = 6'($urandom_range(1, 15));
            else if (k <= 2) ex = 6'b010000;
            else if (k <= 4) ex = 6'b100000;
            else if (k == 5) ex = 6'($urandom_range(1, 63));
            else ex = 6'd0;
            ba = ($urandom_range(0, 4) == 0) ? PB + 64'(4 * $urandom_range(0, 7)) : PB + 64'h10;
            cyc($urandom_range(0, 59) == 0, ex, $urandom_range(0, 9) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) != 0, ba, PB + 64'(4 * $urandom_range(0, 7)));
        end

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain actual=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
